// File: rtl/mem_access_sequencer_pkg.sv
// Shared types and constants for the memory access sequencer.
package mem_seq_pkg;

  localparam int LAT_CNT_W         = 4;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ADDR_WIDTH    = 9;
  localparam int DEF_READ_LATENCY  = 1;
  localparam int DEF_WRITE_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    FIN     = 2'd3
  } seq_state_e;

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Control-unit and RAM signals of the sequencer; slave = sequencer side.
// MEM_SEQ_STATS_EN adds the rd_count/wr_count statistics outputs.
interface mem_access_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
);
  logic                  req_read;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  Mem_Read;
  logic                  Mem_Write;
  logic                  Mem_enable512x32;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data_to_chip;
  logic [DATA_WIDTH-1:0] mem_data_from_chip;
`ifdef MEM_SEQ_STATS_EN
  logic [15:0]           rd_count;
  logic [15:0]           wr_count;
`endif

  modport slave (
    input  req_read, req_write, addr, wdata, mem_data_from_chip,
    output busy, done, err, rdata, Mem_Read, Mem_Write, Mem_enable512x32,
           mem_address, mem_data_to_chip
`ifdef MEM_SEQ_STATS_EN
    , rd_count, wr_count
`endif
  );

  modport master (
    output req_read, req_write, addr, wdata, mem_data_from_chip,
    input  busy, done, err, rdata, Mem_Read, Mem_Write, Mem_enable512x32,
           mem_address, mem_data_to_chip
`ifdef MEM_SEQ_STATS_EN
    , rd_count, wr_count
`endif
  );
endinterface

// File: rtl/mem_access_sequencer_wait_counter.sv
// Load/decrement down-counter with zero flag, shared by both wait states.
module mem_wait_counter
  import mem_seq_pkg::*;
(
  input  logic                 Clock,
  input  logic                 clear,
  input  logic                 load,
  input  logic [LAT_CNT_W-1:0] load_val,
  input  logic                 dec,
  output logic                 zero
);
  logic [LAT_CNT_W-1:0] cnt;

  always_ff @(posedge Clock) begin
    if (!clear)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences single read/write transfers to the 512x32 RAM with registered strobes.
// Optional MEM_SEQ_STATS_EN adds saturating completion counters.
//
// state   | meaning
// IDLE    | sample req_read/req_write
// RD_WAIT | Mem_Read + enable held, capture data when counter hits 0
// WR_WAIT | Mem_Write + enable held until counter hits 0
// FIN     | done pulse (err if both requests seen), back to IDLE
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int READ_LATENCY  = DEF_READ_LATENCY,
  parameter int WRITE_LATENCY = DEF_WRITE_LATENCY
) (
  input  logic                  Clock,
  input  logic                  clear,
  mem_access_sequencer_if.slave bus
);
  seq_state_e            state, state_nxt;
  logic                  cnt_load, cnt_dec, cnt_zero;
  logic [LAT_CNT_W-1:0]  cnt_load_val;
  logic                  latch_addr, latch_wdata, cap_rd, err_set;
  logic                  busy_q, done_q, err_q, rd_q, wr_q, en_q;
  logic [DATA_WIDTH-1:0] rdata_q, wdata_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  mem_wait_counter u_wait_cnt (
    .Clock    (Clock),
    .clear    (clear),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    latch_addr   = 1'b0;
    latch_wdata  = 1'b0;
    cap_rd       = 1'b0;
    err_set      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_read && bus.req_write) begin
          err_set   = 1'b1;
          state_nxt = FIN;
        end else if (bus.req_read) begin
          latch_addr   = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = LAT_CNT_W'(READ_LATENCY - 1);
          state_nxt    = RD_WAIT;
        end else if (bus.req_write) begin
          latch_addr   = 1'b1;
          latch_wdata  = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = LAT_CNT_W'(WRITE_LATENCY - 1);
          state_nxt    = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_zero) begin
          cap_rd    = 1'b1;
          state_nxt = FIN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WR_WAIT: begin
        if (cnt_zero) state_nxt = FIN;
        else          cnt_dec   = 1'b1;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge Clock) begin
    if (!clear) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      en_q    <= 1'b0;
      rdata_q <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == FIN);
      err_q  <= err_set;
      rd_q   <= (state_nxt == RD_WAIT);
      wr_q   <= (state_nxt == WR_WAIT);
      en_q   <= (state_nxt == RD_WAIT) || (state_nxt == WR_WAIT);
      if (latch_addr)  addr_q  <= bus.addr;
      if (latch_wdata) wdata_q <= bus.wdata;
      if (cap_rd)      rdata_q <= bus.mem_data_from_chip;
    end
  end

  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.err              = err_q;
  assign bus.rdata            = rdata_q;
  assign bus.Mem_Read         = rd_q;
  assign bus.Mem_Write        = wr_q;
  assign bus.Mem_enable512x32 = en_q;
  assign bus.mem_address      = addr_q;
  assign bus.mem_data_to_chip = wdata_q;

`ifdef MEM_SEQ_STATS_EN
  logic [15:0] rd_cnt, wr_cnt;

  always_ff @(posedge Clock) begin
    if (!clear) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (state_nxt == FIN) begin
      if (state == RD_WAIT && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      if (state == WR_WAIT && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
    end
  end

  assign bus.rd_count = rd_cnt;
  assign bus.wr_count = wr_cnt;
`endif
endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
Sequences every datapath-to-memory transfer between the CPU control unit/datapath (MAR address, MDR write data) and the 512x32 RAM. It accepts single read/write requests over a level/done handshake and drives the RAM read, write and enable strobes for a parameterised number of wait cycles. It captures read data into a holding register for the MDR and flags illegal simultaneous read+write requests.

Parameters:
DATA_WIDTH, 32, memory word width
ADDR_WIDTH, 9, RAM address width (512 words)
READ_LATENCY, 1, cycles Mem_Read/enable are held before data is captured; legal range 1..15
WRITE_LATENCY, 1, cycles Mem_Write/enable are held; legal range 1..15

Ports:
Clock  in  1  system clock, rising edge
clear  in  1  synchronous active-low reset
req_read  in  1  read request from control unit (level)
req_write  in  1  write request from control unit (level)
addr  in  ADDR_WIDTH  address from MAR
wdata  in  DATA_WIDTH  write data from MDR
busy  out  1  access in progress (state != IDLE)
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse, coincident with done, when both requests were seen
rdata  out  DATA_WIDTH  captured read data, held until next read completes
Mem_Read  out  1  RAM read strobe
Mem_Write  out  1  RAM write strobe
Mem_enable512x32  out  1  RAM enable
mem_address  out  ADDR_WIDTH  registered RAM address
mem_data_to_chip  out  DATA_WIDTH  registered RAM write data
mem_data_from_chip  in  DATA_WIDTH  RAM read data

Behaviour:
- Reset (clear=0 at a rising edge): state=IDLE; all outputs 0, including rdata, mem_address and mem_data_to_chip. Reset overrides any access in progress. The RAM strobes drop on the same edge and no done is produced.
- FSM states: IDLE, RD_WAIT, WR_WAIT, FIN.
- IDLE: requests are sampled only here.
  - req_read only: latch addr into mem_address; wait counter = READ_LATENCY-1; go to RD_WAIT.
  - req_write only: latch addr and wdata; counter = WRITE_LATENCY-1; go to WR_WAIT.
  - Both high: no RAM access; set err; go to FIN.
  - Neither high: stay in IDLE.
- RD_WAIT: Mem_Read=1, Mem_enable512x32=1.
  - Counter nonzero: decrement.
  - Counter zero: capture mem_data_from_chip into rdata; go to FIN.
- WR_WAIT: Mem_Write=1, Mem_enable512x32=1.
  - Counter nonzero: decrement.
  - Counter zero: go to FIN.
- FIN: done=1 (err=1 if flagged); strobes 0; go to IDLE unconditionally.
- Timing: a request sampled at edge k asserts the strobes for cycles k..k+L-1 (L = latency). done is high in the cycle after edge k+L. Access period is L+2 cycles from request sample to IDLE re-entry.
- Strobes are registered outputs decoded from state. Mem_Read and Mem_Write are never high together.
- Requests while busy are ignored. A request still high in IDLE after done starts a new access, so the control unit must drop it on done.
- addr/wdata changes during an access have no effect; the latched copies are used.
- rdata is unchanged by writes, errors and reset-free idle periods.
- Counter width: 4 bits; no wrap, since it only counts down to 0.

Optional Feature:
MEM_SEQ_STATS_EN
- Defined: adds outputs rd_count and wr_count (16 bits each), cleared by reset.
  - Each increments when FIN is entered from RD_WAIT or WR_WAIT respectively.
  - Each saturates at 16'hFFFF.
  - Error completions are not counted.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mem_seq_pkg holds:
  - the state enum (IDLE=2'd0, RD_WAIT=2'd1, WR_WAIT=2'd2, FIN=2'd3)
  - default latency constants
  - LAT_CNT_W=4
- One natural sub-module, mem_wait_counter: a load/decrement/zero-flag down-counter used by both wait states.

Test Plan:
- Reset: hold clear=0 for 2 cycles with req_read=1 -> every output 0, busy=0, no strobes.
- Read, READ_LATENCY=1: RAM[0x005]=32'hDEADBEEF; pulse req_read with addr=9'h005 -> Mem_Read high 1 cycle, done next cycle, rdata=32'hDEADBEEF.
- Write then read, WRITE_LATENCY=1: write 32'h12345678 to 9'h1FF, then read 9'h1FF -> Mem_Write high exactly 1 cycle; readback rdata=32'h12345678; rdata unchanged by the write.
- Latency=3: read from 9'h010 -> Mem_Read/enable high 3 consecutive cycles; done at cycle 4 after the sample edge; busy high throughout.
- Both requests high in IDLE -> no strobe asserted; done=1 and err=1 in the same single cycle; rdata unchanged.
- Reset mid-read (clear=0 during RD_WAIT, READ_LATENCY=3) -> strobes 0 next edge, no done pulse, rdata=0, state IDLE; a subsequent read completes normally.
